// File: rtl/apb_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the APB arbiter bridge.
package apb_arb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} arb_state_t;

  localparam int unsigned PPROT_W = 3;
  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned IDX_W   = 4;

  // First set bit of req searching upward from ptr+1, wrapping modulo n.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr,
                                               input int unsigned        n);
    logic [IDX_W-1:0] pick;
    logic             found;
    logic [31:0]      cand;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      cand = (32'(ptr) + k) % n;
      if (k <= n && !found && req[cand[IDX_W-1:0]]) begin
        pick  = cand[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/apb_rr_picker.sv
// Combinational round-robin selector: request vector and last-grant pointer in, valid and index out.
module apb_rr_picker
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  assign valid = |req;
  assign idx   = rr_pick(MAX_REQ'(req), ptr, NUM_REQ);

endmodule

// File: rtl/apb_rr_arbiter_bridge.sv
// Round-robin bridge sharing one APB completer between NUM_REQ APB requesters.
// Optional downstream watchdog enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter_bridge
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                            PCLK,
  input  logic                            PRESET,
  input  logic [NUM_REQ-1:0]              s_psel,
  input  logic [NUM_REQ-1:0]              s_penable,
  input  logic [NUM_REQ-1:0]              s_pwrite,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_paddr,
  input  logic [NUM_REQ*PPROT_W-1:0]      s_pprot,
  input  logic [NUM_REQ-1:0]              s_pnse,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_pwdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_pstrb,
  output logic [NUM_REQ-1:0]              s_pready,
  output logic [DATA_WIDTH-1:0]           s_prdata,
  output logic [NUM_REQ-1:0]              s_pslverr,
  output logic [ADDR_WIDTH-1:0]           PADDR,
  output logic [PPROT_W-1:0]              PPROT,
  output logic                            PNSE,
  output logic                            PSEL,
  output logic                            PENABLE,
  output logic                            PWRITE,
  output logic [DATA_WIDTH-1:0]           PWDATA,
  output logic [DATA_WIDTH/8-1:0]         PSTRB,
  input  logic                            PREADY,
  input  logic [DATA_WIDTH-1:0]           PRDATA,
  input  logic                            PSLVERR
);

  localparam int unsigned SW = DATA_WIDTH / 8;

  arb_state_t             state;
  logic [IDX_W-1:0]       grant;
  logic [IDX_W-1:0]       ptr;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;
  logic                   timeout_hit;
  logic                   done;

  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [PPROT_W-1:0]     sel_prot;
  logic                   sel_nse;
  logic                   sel_write;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic [SW-1:0]          sel_strb;

  logic                   unused_inputs;
  assign unused_inputs = &{1'b0, s_penable, (TIMEOUT_CYCLES != 0)};

  apb_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (s_psel),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_prot  = '0;
    sel_nse   = 1'b0;
    sel_write = 1'b0;
    sel_wdata = '0;
    sel_strb  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_addr  = s_paddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_prot  = s_pprot[i*PPROT_W +: PPROT_W];
        sel_nse   = s_pnse[i];
        sel_write = s_pwrite[i];
        sel_wdata = s_pwdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb  = s_pstrb[i*SW +: SW];
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // The wait cycle that would bring the count to TIMEOUT_CYCLES is the one that fires.
  assign timeout_hit = (state == ACCESS) && !PREADY &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wait_cnt <= '0;
    end else if (state == IDLE && pick_valid) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !PREADY) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign done     = (state == ACCESS) && (PREADY || timeout_hit);
  assign s_prdata = timeout_hit ? '0 : PRDATA;

  always_comb begin
    s_pready  = '0;
    s_pslverr = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (done && grant == IDX_W'(i)) begin
        s_pready[i]  = 1'b1;
        s_pslverr[i] = timeout_hit | PSLVERR;
      end
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= IDLE;
      grant   <= '0;
      ptr     <= IDX_W'(NUM_REQ - 1);
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PADDR   <= '0;
      PPROT   <= '0;
      PNSE    <= 1'b0;
      PWRITE  <= 1'b0;
      PWDATA  <= '0;
      PSTRB   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant   <= pick_idx;
            PADDR   <= sel_addr;
            PPROT   <= sel_prot;
            PNSE    <= sel_nse;
            PWRITE  <= sel_write;
            PWDATA  <= sel_wdata;
            PSTRB   <= sel_strb;
            PSEL    <= 1'b1;
            PENABLE <= 1'b0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (done) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            ptr     <= grant;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter_bridge.sv
// Randomized self-checking bench for apb_rr_arbiter_bridge against a transaction-level reference model.
module tb_apb_rr_arbiter_bridge;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [N-1:0]    s_psel, s_penable, s_pwrite, s_pnse;
  logic [N*AW-1:0] s_paddr;
  logic [N*3-1:0]  s_pprot;
  logic [N*DW-1:0] s_pwdata;
  logic [N*SW-1:0] s_pstrb;
  logic [N-1:0]    s_pready, s_pslverr;
  logic [DW-1:0]   s_prdata;
  logic [AW-1:0]   PADDR;
  logic [2:0]      PPROT;
  logic            PNSE, PSEL, PENABLE, PWRITE;
  logic [DW-1:0]   PWDATA;
  logic [SW-1:0]   PSTRB;
  logic            PREADY;
  logic [DW-1:0]   PRDATA;
  logic            PSLVERR;

  always #5 PCLK = ~PCLK;

  apb_rr_arbiter_bridge #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(256)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pprot(s_pprot), .s_pnse(s_pnse),
    .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .PADDR(PADDR), .PPROT(PPROT), .PNSE(PNSE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  // Requester-side transaction state
  logic [N-1:0]  up_sel, up_en, up_write, up_nse;
  logic [AW-1:0] up_addr  [N];
  logic [2:0]    up_prot  [N];
  logic [DW-1:0] up_wdata [N];
  logic [SW-1:0] up_strb  [N];
  logic [N-1:0]  done_prev;

  // Reference model: 0 = no transfer, 1 = setup cycle, 2 = access cycles
  int            m_phase, m_grant, m_ptr;
  logic [AW-1:0] m_addr;
  logic [2:0]    m_prot;
  logic          m_nse, m_write;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_strb;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pack_up();
    s_psel    = up_sel;
    s_penable = up_en;
    s_pwrite  = up_write;
    s_pnse    = up_nse;
    for (int i = 0; i < N; i++) begin
      s_paddr[i*AW +: AW]  = up_addr[i];
      s_pprot[i*3 +: 3]    = up_prot[i];
      s_pwdata[i*DW +: DW] = up_wdata[i];
      s_pstrb[i*SW +: SW]  = up_strb[i];
    end
  endtask

  task automatic new_txn(input int i);
    up_sel[i]   = 1'b1;
    up_en[i]    = 1'b0;
    up_write[i] = 1'($urandom);
    up_nse[i]   = 1'($urandom);
    up_addr[i]  = $urandom;
    up_prot[i]  = 3'($urandom);
    up_wdata[i] = $urandom;
    up_strb[i]  = SW'($urandom);
  endtask

  task automatic clear_up();
    up_sel = '0; up_en = '0; up_write = '0; up_nse = '0;
    for (int i = 0; i < N; i++) begin
      up_addr[i] = '0; up_prot[i] = '0; up_wdata[i] = '0; up_strb[i] = '0;
    end
    done_prev = '0;
  endtask

  // Winner is the requester with the smallest forward distance past the last grant.
  function automatic int rr_ref(input logic [N-1:0] req, input int ptr);
    int best, bestd, d;
    best  = -1;
    bestd = N + 1;
    for (int i = 0; i < N; i++) begin
      d = (i - ptr - 1 + 2 * N) % N;
      if (req[i] && d < bestd) begin
        best  = i;
        bestd = d;
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_grant = 0; m_ptr = N - 1;
  endtask

  task automatic model_step();
    if (m_phase == 0) begin
      if (|up_sel) begin
        m_grant = rr_ref(up_sel, m_ptr);
        m_addr  = up_addr[m_grant];  m_prot  = up_prot[m_grant];
        m_nse   = up_nse[m_grant];   m_write = up_write[m_grant];
        m_wdata = up_wdata[m_grant]; m_strb  = up_strb[m_grant];
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (PREADY) begin
      m_ptr   = m_grant;
      m_phase = 0;
    end
  endtask

  task automatic check_cycle();
    logic [N-1:0] exp_rdy;
    logic         fin;
    fin     = (m_phase == 2) && PREADY;
    exp_rdy = fin ? N'(1 << m_grant) : '0;
    check_eq("psel", 64'(PSEL), 64'(m_phase != 0));
    check_eq("penable", 64'(PENABLE), 64'(m_phase == 2));
    if (m_phase != 0) begin
      check_eq("paddr", 64'(PADDR), 64'(m_addr));
      check_eq("pprot", 64'(PPROT), 64'(m_prot));
      check_eq("pnse", 64'(PNSE), 64'(m_nse));
      check_eq("pwrite", 64'(PWRITE), 64'(m_write));
      check_eq("pwdata", 64'(PWDATA), 64'(m_wdata));
      check_eq("pstrb", 64'(PSTRB), 64'(m_strb));
    end
    check_eq("s_pready", 64'(s_pready), 64'(exp_rdy));
    check_eq("s_pslverr", 64'(s_pslverr), 64'(PSLVERR ? exp_rdy : '0));
    if (fin) check_eq("s_prdata", 64'(s_prdata), 64'(PRDATA));
  endtask

  initial begin
    int mode;
    PRESET = 1'b1;
    PREADY = 1'b0; PRDATA = '0; PSLVERR = 1'b0;
    clear_up();
    pack_up();
    model_reset();
    @(negedge PCLK);
    @(negedge PCLK);
    check_eq("rst_psel", 64'(PSEL), 64'd0);
    check_eq("rst_penable", 64'(PENABLE), 64'd0);
    check_eq("rst_paddr", 64'(PADDR), 64'd0);
    check_eq("rst_pwdata", 64'(PWDATA), 64'd0);
    check_eq("rst_fields", 64'({PPROT, PNSE, PWRITE, PSTRB}), 64'd0);
    check_eq("rst_s_pready", 64'(s_pready), 64'd0);
    check_eq("rst_s_pslverr", 64'(s_pslverr), 64'd0);
    PRESET = 1'b0;

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge PCLK);
      if (m_phase == 2 && ($urandom % 120) == 0) begin
        #2 PRESET = 1'b1;
        #1;
        check_eq("arst_psel", 64'(PSEL), 64'd0);
        check_eq("arst_penable", 64'(PENABLE), 64'd0);
        check_eq("arst_s_pready", 64'(s_pready), 64'd0);
        clear_up();
        pack_up();
        model_reset();
        @(negedge PCLK);
        PRESET = 1'b0;
        // Port 3 competes, but port 0 must win first after reset.
        new_txn(0);
        new_txn(3);
        pack_up();
        #1;
        check_cycle();
        model_step();
        continue;
      end

      for (int i = 0; i < N; i++) begin
        if (done_prev[i]) begin
          if (($urandom % 3) == 0) new_txn(i);
          else up_sel[i] = 1'b0;
          up_en[i] = up_sel[i] & ~up_en[i] ? 1'b0 : up_en[i];
        end else if (up_sel[i]) begin
          up_en[i] = 1'b1;
          if (($urandom % 100) == 0) up_sel[i] = 1'b0;
        end else if (($urandom % 3) == 0) begin
          new_txn(i);
        end
      end
      pack_up();

      mode = (cyc / 300) % 3;
      if (mode == 0) PREADY = 1'b1;
      else if (mode == 1) PREADY = 1'($urandom);
      else PREADY = (($urandom % 6) == 0);
      PRDATA  = $urandom;
      PSLVERR = (($urandom % 4) == 0);

      #1;
      check_cycle();
      done_prev = s_pready & up_sel;
      model_step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_rr_arbiter_bridge.md
Name: apb_rr_arbiter_bridge

Overview:
- Shares one APB completer bus between NUM_REQ upstream APB requesters using round-robin arbitration.
- Each upstream port looks like an APB completer; the downstream port is an APB requester.
- A granted transfer is replayed downstream as a full SETUP/ACCESS sequence.
- Non-granted requesters are held in their ACCESS phase with s_pready low.

Parameters:
- NUM_REQ, 4, number of upstream requesters (2..16)
- ADDR_WIDTH, 32, PADDR width
- DATA_WIDTH, 32, data width (multiple of 8)
- TIMEOUT_CYCLES, 256, watchdog limit (used only with the optional feature)

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset, asynchronous, active-high
- s_psel  in  NUM_REQ  per-requester select
- s_penable  in  NUM_REQ  per-requester enable
- s_pwrite  in  NUM_REQ  per-requester write
- s_paddr  in  NUM_REQ*ADDR_WIDTH  packed addresses, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- s_pprot  in  NUM_REQ*3  packed protection
- s_pnse  in  NUM_REQ  non-secure extension
- s_pwdata  in  NUM_REQ*DATA_WIDTH  packed write data
- s_pstrb  in  NUM_REQ*DATA_WIDTH/8  packed strobes
- s_pready  out  NUM_REQ  per-requester ready
- s_prdata  out  DATA_WIDTH  read data, broadcast to all ports
- s_pslverr  out  NUM_REQ  per-requester error
- PADDR  out  ADDR_WIDTH  downstream address
- PPROT  out  3  downstream protection
- PNSE  out  1  downstream non-secure extension
- PSEL  out  1  downstream select
- PENABLE  out  1  downstream enable
- PWRITE  out  1  downstream write
- PWDATA  out  DATA_WIDTH  downstream write data
- PSTRB  out  DATA_WIDTH/8  downstream strobes
- PREADY  in  1  downstream ready
- PRDATA  in  DATA_WIDTH  downstream read data
- PSLVERR  in  1  downstream error

Behaviour:
- Reset (PRESET high, asynchronous):
  - state=IDLE; PSEL=0, PENABLE=0; PADDR/PPROT/PNSE/PWRITE/PWDATA/PSTRB=0.
  - grant index=0; last-grant pointer=NUM_REQ-1, so port 0 has first priority.
  - s_pready=0, s_pslverr=0.
  - Reset mid-transfer abandons it silently; upstream requesters must also be reset.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any s_psel is set, pick the first set bit searching upward from pointer+1, modulo NUM_REQ.
  - Register that port's PADDR/PPROT/PNSE/PWRITE/PWDATA/PSTRB.
  - Set PSEL=1, PENABLE=0; next state SETUP.
  - No request: stay in IDLE.
- SETUP: PENABLE<=1; next state ACCESS. Always exactly one cycle.
- ACCESS, PREADY=0: hold all downstream outputs stable.
- ACCESS, PREADY=1:
  - Combinationally assert s_pready[grant]=1 and s_pslverr[grant]=PSLVERR.
  - s_prdata=PRDATA, same cycle.
  - Registered: PSEL=0, PENABLE=0, pointer<=grant, next state IDLE.
- Latency:
  - Upstream s_psel rise at cycle 0 gives downstream PSEL at cycle 1 and PENABLE at cycle 2.
  - With zero downstream wait states, s_pready is seen at cycle 2.
  - Minimum 3 cycles per transfer, because IDLE is always visited between transfers.
- s_pready and s_pslverr are 0 for every port other than the granted one, and 0 outside ACCESS.
- Only s_psel is sampled for arbitration. Requester signals are captured once, in IDLE; later upstream changes are ignored until the next grant.
- Simultaneous requests: round-robin only, no fixed priority after reset. A requester re-asserting immediately after completion is ranked last.
- A requester dropping s_psel while waiting is simply not granted. A requester dropping s_psel while granted still completes downstream, and its response is discarded.
- Downstream outputs are registered; s_pready, s_pslverr and s_prdata are combinational from PREADY, PSLVERR and PRDATA.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to SETUP and increments each ACCESS cycle with PREADY=0.
  - When the counter reaches TIMEOUT_CYCLES, the granted port gets s_pready=1, s_pslverr=1 and s_prdata=0.
  - Downstream PSEL/PENABLE drop and the FSM returns to IDLE. This deliberately abandons the downstream transfer.
  - PREADY arriving in the same cycle as the timeout wins: normal completion.
- Not defined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Package apb_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS} arb_state_t
  - constant PPROT_W=3
  - function rr_pick(req, ptr) returning the grant index
- Sub-module apb_rr_picker: combinational round-robin selector (req vector and pointer in; valid and index out). Unit-testable separately.

Test Plan:
- Single port 2 write, addr 0x1000_0040, data 0xDEADBEEF, strb 0xF, PREADY tied 1 -> downstream PSEL at cycle 1, PENABLE at cycle 2 with identical fields; s_pready[2]=1 at cycle 2; other s_pready bits 0.
- Ports 0–3 request simultaneously after reset, each holding until served -> grants in order 0,1,2,3. Port 0 re-requests immediately -> granted after 3 (wrap).
- Port 1 read, PREADY low for 5 ACCESS cycles, then PRDATA=0x1234_5678 with PSLVERR=1 -> downstream stable for 5 cycles; s_prdata=0x12345678 and s_pslverr[1]=1 on the completion cycle only.
- PRESET asserted during ACCESS with port 3 granted -> PSEL=0, PENABLE=0, s_pready=0 immediately (asynchronous). After release, pending port 0 is granted first.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, PREADY stuck 0 -> on the 8th ACCESS wait cycle s_pready[g]=1, s_pslverr[g]=1, s_prdata=0; FSM returns to IDLE.
- Port 2 drops s_psel while waiting behind port 0 -> port 2 is never granted; only port 0 completes.
